// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK byte frames from uart_rx into a single valid/ready output slot.
// Define UART_FRAME_PARSER_STATS_EN to build the saturating error counters; otherwise o_err_* read 0.
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE     = 8'hAA,
  parameter int         MAX_PAYLOAD  = 4,
  parameter int         TIMEOUT_CLKS = 50000,
  parameter int         CNT_W        = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx_dv,
  input  logic [7:0]               i_rx_byte,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic [7:0]               o_cmd,
  output logic [3:0]               o_len,
  output logic [8*MAX_PAYLOAD-1:0] o_payload,
  output logic [CNT_W-1:0]         o_err_chk,
  output logic [CNT_W-1:0]         o_err_len,
  output logic [CNT_W-1:0]         o_err_timeout,
  output logic [CNT_W-1:0]         o_err_ovf
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {S_SOF, S_CMD, S_LEN, S_PAY, S_CHK} state_t;

  state_t                   state;
  logic [7:0]               cmd;
  logic [3:0]               len;
  logic [3:0]               idx;
  logic [7:0]               acc;
  logic [7:0]               pay [MAX_PAYLOAD];
  logic [8*MAX_PAYLOAD-1:0] pay_flat;
  logic [TW-1:0]            tmo_cnt;
  logic                     commit;
  logic                     len_bad;
  logic                     tmo_hit;

  // Per-cycle frame events derived from the current byte strobe and parser state
  always_comb begin
    commit  = 1'b0;
    len_bad = 1'b0;
    tmo_hit = 1'b0;
    if (i_rx_dv) begin
      commit  = (state == S_CHK) && (i_rx_byte == acc);
      len_bad = (state == S_LEN) && (i_rx_byte > 8'(MAX_PAYLOAD));
    end else begin
      tmo_hit = (state != S_SOF) && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
    end
  end

  // Flatten the payload buffer; buffer is cleared per frame so bytes beyond len are already 0
  always_comb begin
    pay_flat = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      pay_flat[8*k +: 8] = pay[k];
    end
  end

  // Byte sequencer: frame assembly, checksum accumulation and inter-byte timeout
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_SOF;
      cmd     <= 8'h00;
      len     <= 4'h0;
      idx     <= 4'h0;
      acc     <= 8'h00;
      tmo_cnt <= '0;
      for (int k = 0; k < MAX_PAYLOAD; k++) pay[k] <= 8'h00;
    end else begin
      if (i_rx_dv || state == S_SOF || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (i_rx_dv) begin
        case (state)
          S_SOF: begin
            if (i_rx_byte == SOF_BYTE) state <= S_CMD;
          end
          S_CMD: begin
            cmd   <= i_rx_byte;
            acc   <= i_rx_byte;
            len   <= 4'h0;
            idx   <= 4'h0;
            for (int k = 0; k < MAX_PAYLOAD; k++) pay[k] <= 8'h00;
            state <= S_LEN;
          end
          S_LEN: begin
            acc <= acc ^ i_rx_byte;
            if (len_bad) begin
              state <= S_SOF;
            end else if (i_rx_byte == 8'h00) begin
              len   <= 4'h0;
              state <= S_CHK;
            end else begin
              len   <= i_rx_byte[3:0];
              idx   <= 4'h0;
              state <= S_PAY;
            end
          end
          S_PAY: begin
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              if (idx == 4'(k)) pay[k] <= i_rx_byte;
            end
            acc <= acc ^ i_rx_byte;
            if (idx == len - 4'd1) begin
              state <= S_CHK;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          S_CHK:   state <= S_SOF;
          default: state <= S_SOF;
        endcase
      end else if (tmo_hit) begin
        state <= S_SOF;
      end
    end
  end

  // Output slot: a commit loads unless the slot is full and not being drained this cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'h00;
      o_len       <= 4'h0;
      o_payload   <= '0;
    end else if (commit && !(o_cmd_valid && !i_cmd_ready)) begin
      o_cmd_valid <= 1'b1;
      o_cmd       <= cmd;
      o_len       <= len;
      o_payload   <= pay_flat;
    end else if (o_cmd_valid && i_cmd_ready) begin
      o_cmd_valid <= 1'b0;
    end
  end

`ifdef UART_FRAME_PARSER_STATS_EN
  logic chk_bad;
  logic ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    if (ev && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Drop and checksum-failure events for the statistics counters
  always_comb begin
    chk_bad = i_rx_dv && (state == S_CHK) && (i_rx_byte != acc);
    ovf     = commit && o_cmd_valid && !i_cmd_ready;
  end

  // Saturating error counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err_chk     <= '0;
      o_err_len     <= '0;
      o_err_timeout <= '0;
      o_err_ovf     <= '0;
    end else begin
      o_err_chk     <= sat_inc(o_err_chk, chk_bad);
      o_err_len     <= sat_inc(o_err_len, len_bad);
      o_err_timeout <= sat_inc(o_err_timeout, tmo_hit);
      o_err_ovf     <= sat_inc(o_err_ovf, ovf);
    end
  end
`else
  assign o_err_chk     = '0;
  assign o_err_len     = '0;
  assign o_err_timeout = '0;
  assign o_err_ovf     = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations for the listed scenarios.
module tb_uart_frame_parser;

  localparam int MAXP = 4;
  localparam int TO   = 40;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk;
  logic              i_rst_n;
  logic              i_rx_dv;
  logic [7:0]        i_rx_byte;
  logic              o_cmd_valid;
  logic              i_cmd_ready;
  logic [7:0]        o_cmd;
  logic [3:0]        o_len;
  logic [8*MAXP-1:0] o_payload;
  logic [CW-1:0]     o_err_chk;
  logic [CW-1:0]     o_err_len;
  logic [CW-1:0]     o_err_timeout;
  logic [CW-1:0]     o_err_ovf;

  uart_frame_parser #(
    .SOF_BYTE(8'hAA), .MAX_PAYLOAD(MAXP), .TIMEOUT_CLKS(TO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd(o_cmd), .o_len(o_len),
    .o_payload(o_payload), .o_err_chk(o_err_chk), .o_err_len(o_err_len),
    .o_err_timeout(o_err_timeout), .o_err_ovf(o_err_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
`ifdef UART_FRAME_PARSER_STATS_EN
    return (n > CMAX) ? 64'(CMAX) : 64'(n);
`else
    return 64'(0 * n);
`endif
  endfunction

  // Reference model: frame-level view of the byte stream
  bit          m_valid;
  logic [7:0]  m_cmd;
  logic [3:0]  m_len;
  logic [31:0] m_pay;
  int          m_err_chk, m_err_len, m_err_tmo, m_err_ovf;
  bit          m_in;
  logic [7:0]  m_frm[$];
  longint      m_cyc = 0;
  longint      m_last = 0;

  task automatic model_step();
    bit         commit;
    logic [7:0] x;
    commit = 1'b0;
    m_cyc++;
    if (!i_rst_n) begin
      m_valid = 1'b0; m_cmd = 8'h00; m_len = 4'h0; m_pay = 32'h0;
      m_err_chk = 0; m_err_len = 0; m_err_tmo = 0; m_err_ovf = 0;
      m_in = 1'b0; m_frm.delete();
      return;
    end
    if (i_rx_dv) begin
      m_last = m_cyc;
      if (!m_in) begin
        if (i_rx_byte == 8'hAA) begin
          m_in = 1'b1;
          m_frm.delete();
        end
      end else begin
        m_frm.push_back(i_rx_byte);
        if (m_frm.size() == 2 && m_frm[1] > 8'(MAXP)) begin
          m_err_len++;
          m_in = 1'b0;
        end else if (m_frm.size() >= 3 && m_frm.size() == int'(m_frm[1]) + 3) begin
          x = 8'h00;
          for (int i = 0; i < m_frm.size() - 1; i++) x = x ^ m_frm[i];
          if (x == i_rx_byte) commit = 1'b1;
          else m_err_chk++;
          m_in = 1'b0;
        end
      end
    end else if (m_in && (m_cyc - m_last == longint'(TO))) begin
      m_err_tmo++;
      m_in = 1'b0;
    end
    if (commit) begin
      if (m_valid && !i_cmd_ready) begin
        m_err_ovf++;
      end else begin
        m_valid = 1'b1;
        m_cmd   = m_frm[0];
        m_len   = m_frm[1][3:0];
        m_pay   = 32'h0;
        for (int i = 0; i < int'(m_frm[1]); i++) m_pay[8*i +: 8] = m_frm[2+i];
      end
    end else if (m_valid && i_cmd_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("cyc_valid", o_cmd_valid, m_valid);
      if (m_valid) begin
        cmp("cyc_cmd", o_cmd, m_cmd);
        cmp("cyc_len", o_len, m_len);
        cmp("cyc_payload", o_payload, m_pay);
      end
      cmp("cyc_err_chk", o_err_chk, exp_cnt(m_err_chk));
      cmp("cyc_err_len", o_err_len, exp_cnt(m_err_len));
      cmp("cyc_err_timeout", o_err_timeout, exp_cnt(m_err_tmo));
      cmp("cyc_err_ovf", o_err_ovf, exp_cnt(m_err_ovf));
    end
  end

  logic [7:0] seq[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge clk);
    #1;
    i_rx_dv   = 1'b0;
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send(seq[i]);
  endtask

  task automatic release_slot();
    i_cmd_ready = 1'b1;
    idle(1);
    i_cmd_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cmp("rst_valid", o_cmd_valid, 64'h0);
    cmp("rst_payload", o_payload, 64'h0);
    cmp("rst_err_chk", o_err_chk, 64'h0);
    i_rst_n = 1'b1;

    // Noise outside a frame is ignored, then a good two-byte frame
    send(8'h12); send(8'h34);
    seq = '{8'hAA, 8'h10, 8'h02, 8'h05, 8'h06}; send_seq();
    cmp("t1_pre_valid", o_cmd_valid, 64'h0);
    send(8'h11);
    cmp("t1_valid", o_cmd_valid, 64'h1);
    cmp("t1_cmd", o_cmd, 64'h10);
    cmp("t1_len", o_len, 64'h2);
    cmp("t1_payload", o_payload, 64'h0000_0605);
    cmp("t1_model_payload", m_pay, 64'h0000_0605);
    release_slot();
    cmp("t1_release", o_cmd_valid, 64'h0);

    // Bad checksum
    seq = '{8'hAA, 8'h10, 8'h02, 8'h05, 8'h06, 8'h12}; send_seq();
    cmp("t2_valid", o_cmd_valid, 64'h0);
    cmp("t2_err_chk", o_err_chk, exp_cnt(1));

    // Oversize LEN, then zero-length frame
    seq = '{8'hAA, 8'h20, 8'h09}; send_seq();
    cmp("t3_err_len", o_err_len, exp_cnt(1));
    seq = '{8'hAA, 8'h21, 8'h00, 8'h21}; send_seq();
    cmp("t3_valid", o_cmd_valid, 64'h1);
    cmp("t3_cmd", o_cmd, 64'h21);
    cmp("t3_len", o_len, 64'h0);
    cmp("t3_payload", o_payload, 64'h0);
    release_slot();

    // SOF value inside a frame is data; full-length payload
    seq = '{8'hAA, 8'h05, 8'h01, 8'hAA, 8'hAE}; send_seq();
    cmp("sof_data_payload", o_payload, 64'h0000_00AA);
    release_slot();
    seq = '{8'hAA, 8'h07, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07}; send_seq();
    cmp("max_len", o_len, 64'h4);
    cmp("max_payload", o_payload, 64'h0403_0201);
    release_slot();

    // Inter-byte timeout, then recovery
    seq = '{8'hAA, 8'h30, 8'h01}; send_seq();
    idle(TO - 1);
    cmp("t4_pre_tmo", o_err_timeout, exp_cnt(0));
    idle(1);
    cmp("t4_tmo", o_err_timeout, exp_cnt(1));
    seq = '{8'hAA, 8'h33, 8'h00, 8'h33}; send_seq();
    cmp("t4_recover_cmd", o_cmd, 64'h33);
    cmp("t4_recover_valid", o_cmd_valid, 64'h1);
    release_slot();

    // Byte arriving in the expiry cycle wins
    seq = '{8'hAA, 8'h31, 8'h01}; send_seq();
    idle(TO - 1);
    send(8'h55);
    cmp("edge_no_tmo", o_err_timeout, exp_cnt(1));
    send(8'h65);
    cmp("edge_valid", o_cmd_valid, 64'h1);
    cmp("edge_payload", o_payload, 64'h0000_0055);
    release_slot();

    // Slot full: second frame dropped, third loaded with ready on its CHK cycle
    seq = '{8'hAA, 8'h50, 8'h00, 8'h50}; send_seq();
    seq = '{8'hAA, 8'h51, 8'h00, 8'h51}; send_seq();
    cmp("t5_ovf", o_err_ovf, exp_cnt(1));
    cmp("t5_held_cmd", o_cmd, 64'h50);
    seq = '{8'hAA, 8'h52, 8'h00}; send_seq();
    i_cmd_ready = 1'b1;
    send(8'h52);
    i_cmd_ready = 1'b0;
    cmp("t5_swap_cmd", o_cmd, 64'h52);
    cmp("t5_swap_valid", o_cmd_valid, 64'h1);
    cmp("t5_swap_no_ovf", o_err_ovf, exp_cnt(1));
    release_slot();

    // Counter saturation
    for (int i = 0; i < 8; i++) begin
      seq = '{8'hAA, 8'h60, 8'h09}; send_seq();
    end
    cmp("sat_err_len", o_err_len, exp_cnt(9));

    // Reset mid-frame with a pending frame in the slot
    seq = '{8'hAA, 8'h42, 8'h00, 8'h42}; send_seq();
    seq = '{8'hAA, 8'h40, 8'h02, 8'h07}; send_seq();
    i_rst_n = 1'b0;
    idle(1);
    i_rst_n = 1'b1;
    cmp("t6_valid", o_cmd_valid, 64'h0);
    cmp("t6_cmd", o_cmd, 64'h0);
    cmp("t6_len", o_len, 64'h0);
    cmp("t6_err_len", o_err_len, 64'h0);
    cmp("t6_err_ovf", o_err_ovf, 64'h0);
    seq = '{8'hAA, 8'h41, 8'h00, 8'h41}; send_seq();
    cmp("t6_after_valid", o_cmd_valid, 64'h1);
    cmp("t6_after_cmd", o_cmd, 64'h41);
    release_slot();

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
